// File: rtl/yt_trace_pkg.sv
// Shared encodings and record layout for the commit trace buffer.
// Record layout, MSB first: {pc, instr, wb_en, wb_addr, wb_data}.
package yt_trace_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int REC_W_DEF   = PC_W_DEF + INSTR_W_DEF + 1 + REG_AW_DEF + DATA_W_DEF;

    localparam logic [1:0] MODE_FILL   = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_TSTART = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DATA_LSB  = 0;
    localparam int ADDR_LSB  = DATA_LSB + DATA_W_DEF;
    localparam int WBEN_BIT  = ADDR_LSB + REG_AW_DEF;
    localparam int INSTR_LSB = WBEN_BIT + 1;
    localparam int PC_LSB    = INSTR_LSB + INSTR_W_DEF;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   wb_en;
        logic [REG_AW_DEF-1:0]  wb_addr;
        logic [DATA_W_DEF-1:0]  wb_data;
    } trace_rec_t;

    function automatic logic [REC_W_DEF-1:0] pack_rec(
        input logic [PC_W_DEF-1:0]    pc,
        input logic [INSTR_W_DEF-1:0] instr,
        input logic                   wb_en,
        input logic [REG_AW_DEF-1:0]  wb_addr,
        input logic [DATA_W_DEF-1:0]  wb_data
    );
        logic [REC_W_DEF-1:0] v;
        v = '0;
        v[PC_LSB +: PC_W_DEF]       = pc;
        v[INSTR_LSB +: INSTR_W_DEF] = instr;
        v[WBEN_BIT]                 = wb_en;
        v[ADDR_LSB +: REG_AW_DEF]   = wb_addr;
        v[DATA_LSB +: DATA_W_DEF]   = wb_data;
        return v;
    endfunction

    function automatic trace_rec_t unpack_rec(input logic [REC_W_DEF-1:0] v);
        trace_rec_t r;
        r.pc      = v[PC_LSB +: PC_W_DEF];
        r.instr   = v[INSTR_LSB +: INSTR_W_DEF];
        r.wb_en   = v[WBEN_BIT];
        r.wb_addr = v[ADDR_LSB +: REG_AW_DEF];
        r.wb_data = v[DATA_LSB +: DATA_W_DEF];
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_ram.sv
// Simple dual-port record store: synchronous write, asynchronous read.
module trace_ram #(
    parameter int  DEPTH = 512,
    parameter int  WIDTH = 102,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Retired-instruction trace capture into a circular buffer with
// FILL / WRAP / trigger-start modes and oldest-first valid/ready readout.
module commit_trace_buffer
    import yt_trace_pkg::*;
#(
    parameter int  DEPTH   = 512,
    parameter int  PC_W    = PC_W_DEF,
    parameter int  INSTR_W = INSTR_W_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  REG_AW  = REG_AW_DEF,
    localparam int REC_W   = PC_W + INSTR_W + 1 + REG_AW + DATA_W,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_wb_en,
    input  logic [REG_AW-1:0]  i_wb_addr,
    input  logic [DATA_W-1:0]  i_wb_data,
    input  logic [1:0]         i_mode,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic               i_trigger,
    input  logic [CW-1:0]      i_post_count,
    input  logic               i_rd_ready,
    output logic               o_rd_valid,
    output logic [REC_W-1:0]   o_rd_data,
    output logic [CW-1:0]      o_count,
    output logic [2:0]         o_state,
    output logic               o_overflow
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          state_r, state_s;
    logic [1:0]      mode_r, mode_s;
    logic [AW-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]   count_r, count_s, remain_r, remain_s, post_sat_s;
    logic            overflow_r, overflow_s;
    logic            capture_s, pop_s, full_s, abort_s;
    logic [REC_W-1:0] wr_rec_s;

    assign wr_rec_s   = {i_pc, i_instr, i_wb_en, i_wb_addr, i_wb_data};
    assign full_s     = (count_r == FULL);
    assign abort_s    = i_abort && (state_r != ST_IDLE);
    assign post_sat_s = (i_post_count > FULL) ? FULL : i_post_count;
    assign capture_s  = i_valid && !abort_s &&
                        ((state_r == ST_CAPTURE) || (state_r == ST_POST) ||
                         ((state_r == ST_ARMED) && i_trigger));
    assign pop_s      = (state_r == ST_DONE) && (count_r != '0) && i_rd_ready && !abort_s;

    // Next-state, pointer and counter logic.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        remain_s   = remain_r;
        overflow_s = overflow_r;

        if (abort_s) begin
            state_s  = ST_IDLE;
            count_s  = '0;
            remain_s = '0;
        end else begin
            // A capture into a full WRAP buffer drops the oldest record.
            if (capture_s) begin
                wr_ptr_s = wr_ptr_r + AW'(1);
                if (full_s) begin
                    rd_ptr_s   = rd_ptr_r + AW'(1);
                    overflow_s = 1'b1;
                end else begin
                    count_s = count_r + CW'(1);
                end
            end else if (pop_s) begin
                rd_ptr_s = rd_ptr_r + AW'(1);
                count_s  = count_r - CW'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (i_arm) begin
                        mode_s     = (i_mode == 2'd3) ? MODE_FILL : i_mode;
                        wr_ptr_s   = '0;
                        rd_ptr_s   = '0;
                        count_s    = '0;
                        remain_s   = '0;
                        overflow_s = 1'b0;
                        state_s    = (i_mode == MODE_TSTART) ? ST_ARMED : ST_CAPTURE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (i_trigger) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (mode_r == MODE_WRAP) begin
                        if (i_trigger && (post_sat_s == '0)) begin
                            state_s = ST_DONE;
                        end else if (i_trigger) begin
                            state_s  = ST_POST;
                            remain_s = post_sat_s;
                        end else begin
                            state_s = ST_CAPTURE;
                        end
                    end else if (capture_s && (count_r == FULL - CW'(1))) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_POST: begin
                    if (capture_s) begin
                        remain_s = remain_r - CW'(1);
                        state_s  = (remain_r == CW'(1)) ? ST_DONE : ST_POST;
                    end else begin
                        state_s = ST_POST;
                    end
                end
                ST_DONE: begin
                    if ((count_r == '0) || (pop_s && (count_r == CW'(1)))) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_FILL;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            remain_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            remain_r   <= remain_s;
            overflow_r <= overflow_s;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (capture_s),
        .waddr (wr_ptr_r),
        .wdata (wr_rec_s),
        .raddr (rd_ptr_r),
        .rdata (o_rd_data)
    );

    assign o_rd_valid = (state_r == ST_DONE) && (count_r != '0);
    assign o_count    = count_r;
    assign o_state    = state_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer (DEPTH=8): directed table,
// hand-written sequences and random stimulus against a queue-based model.
module tb_commit_trace_buffer;
    import yt_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int RW    = REC_W_DEF;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_valid;
    logic [31:0]     i_pc, i_instr, i_wb_data;
    logic            i_wb_en;
    logic [4:0]      i_wb_addr;
    logic [1:0]      i_mode;
    logic            i_arm, i_abort, i_trigger, i_rd_ready;
    logic [CW-1:0]   i_post_count;
    logic            o_rd_valid, o_overflow;
    logic [RW-1:0]   o_rd_data;
    logic [CW-1:0]   o_count;
    logic [2:0]      o_state;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of held records plus a phase.
    int            m_state, m_mode, m_remain;
    bit            m_over;
    logic [RW-1:0] m_q[$];

    typedef struct {
        bit arm; bit valid; bit trig; bit ready;
        int st; int cnt; bit ovf;
    } vec_t;
    vec_t tbl[11];

    int            pops;
    bit            was_stall;
    logic [RW-1:0] held;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_mode(i_mode),
        .i_arm(i_arm), .i_abort(i_abort), .i_trigger(i_trigger), .i_post_count(i_post_count),
        .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_count(o_count), .o_state(o_state), .o_overflow(o_overflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_pc();
        return o_rd_data[PC_LSB +: PC_W_DEF];
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input bit trig);
        i_valid   = v;
        i_pc      = pc;
        i_instr   = pc ^ 32'h0000_0013;
        i_wb_en   = pc[2];
        i_wb_addr = pc[6:2];
        i_wb_data = pc * 32'd3;
        i_trigger = trig;
    endtask

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_remain = 0; m_over = 1'b0;
        m_q.delete();
    endtask

    task automatic model_push();
        m_q.push_back(pack_rec(i_pc, i_instr, i_wb_en, i_wb_addr, i_wb_data));
        if (m_q.size() > DEPTH) begin
            m_q.delete(0);
            m_over = 1'b1;
        end
    endtask

    task automatic model_step();
        int p;
        if (reset) begin
            model_reset();
            return;
        end
        if (i_abort && m_state != 0) begin
            m_state = 0; m_remain = 0;
            m_q.delete();
            return;
        end
        case (m_state)
            0: if (i_arm) begin
                m_mode = (i_mode == 2'd3) ? 0 : int'(i_mode);
                m_q.delete(); m_over = 1'b0; m_remain = 0;
                m_state = (m_mode == 2) ? 1 : 2;
            end
            1: if (i_trigger) begin
                if (i_valid) model_push();
                m_state = 2;
            end
            2: begin
                if (i_valid) model_push();
                if (m_mode == 1) begin
                    if (i_trigger) begin
                        p = (int'(i_post_count) > DEPTH) ? DEPTH : int'(i_post_count);
                        if (p == 0) m_state = 4;
                        else begin m_state = 3; m_remain = p; end
                    end
                end else if (m_q.size() == DEPTH) begin
                    m_state = 4;
                end
            end
            3: if (i_valid) begin
                model_push();
                m_remain--;
                if (m_remain == 0) m_state = 4;
            end
            4: begin
                if (m_q.size() != 0 && i_rd_ready) m_q.delete(0);
                if (m_q.size() == 0) m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_model();
        chk("model_state", o_state, m_state);
        chk("model_count", o_count, m_q.size());
        chk("model_overflow", o_overflow, m_over);
        chk("model_rd_valid", o_rd_valid, (m_state == 4 && m_q.size() != 0));
        if (m_state == 4 && m_q.size() != 0) chk("model_rd_data", o_rd_data, m_q[0]);
    endtask

    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 11; r++) begin
            if (r == 0)      tbl[r] = '{1, 0, 0, 0, 2, 0, 0};
            else if (r < 5)  tbl[r] = '{0, 1, 0, 0, 2, r, 0};
            else if (r == 5) tbl[r] = '{0, 1, 1, 0, 4, 5, 0};
            else             tbl[r] = '{0, 0, 0, 1, (r == 10) ? 0 : 4, 10 - r, 0};
        end

        reset = 1'b1;
        drive(0, 32'h0, 0);
        i_mode = 2'd0; i_arm = 0; i_abort = 0; i_post_count = '0; i_rd_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        chk("reset_state", o_state, 3'd0);
        reset = 1'b0;

        // 1: FILL stops at DEPTH, drains in order.
        i_mode = 2'd0; i_arm = 1; tick(); i_arm = 0;
        chk("s1_capture", o_state, 3'd2);
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h0040_0000 + 32'(4 * k), 0); tick();
            if (k == 7) begin
                chk("s1_done", o_state, 3'd4);
                chk("s1_count", o_count, 4'd8);
            end
        end
        drive(0, 32'h0, 0); i_rd_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("s1_rd_valid", o_rd_valid, 1'b1);
            chk("s1_pc", rd_pc(), 32'h0040_0000 + 32'(4 * k));
            tick();
        end
        chk("s1_idle", o_state, 3'd0);
        i_rd_ready = 0;

        // 2: WRAP with trigger at k=11, post 3.
        i_mode = 2'd1; i_post_count = 4'd3; i_arm = 1; tick(); i_arm = 0;
        for (int k = 0; k < 15; k++) begin
            drive(1, 32'h0040_0000 + 32'(4 * k), k == 11); tick();
            if (k == 11) chk("s2_post", o_state, 3'd3);
        end
        chk("s2_done", o_state, 3'd4);
        chk("s2_overflow", o_overflow, 1'b1);
        chk("s2_count", o_count, 4'd8);
        drive(0, 32'h0, 0); i_rd_ready = 1;
        for (int k = 7; k < 15; k++) begin
            chk("s2_pc", rd_pc(), 32'h0040_0000 + 32'(4 * k));
            tick();
        end
        chk("s2_idle", o_state, 3'd0);
        i_rd_ready = 0;

        // 3: table-driven WRAP with post_count=0 and drain.
        i_mode = 2'd1; i_post_count = 4'd0;
        for (int r = 0; r < 11; r++) begin
            i_arm = tbl[r].arm;
            drive(tbl[r].valid, 32'h0050_0000 + 32'(4 * r), tbl[r].trig);
            i_rd_ready = tbl[r].ready;
            tick();
            chk("s3_state", o_state, tbl[r].st);
            chk("s3_count", o_count, tbl[r].cnt);
            chk("s3_overflow", o_overflow, tbl[r].ovf);
        end
        i_arm = 0; i_rd_ready = 0; drive(0, 32'h0, 0);

        // 4: TSTART ignores records until trigger.
        i_mode = 2'd2; i_arm = 1; tick(); i_arm = 0;
        chk("s4_armed", o_state, 3'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h0040_0000 + 32'(4 * k), 0); tick();
        end
        chk("s4_none_state", o_state, 3'd1);
        chk("s4_none_count", o_count, 4'd0);
        drive(1, 32'h0040_0100, 1); tick();
        chk("s4_trig_state", o_state, 3'd2);
        chk("s4_trig_count", o_count, 4'd1);
        for (int j = 1; j < 8; j++) begin
            drive(1, 32'h0040_0100 + 32'(4 * j), 0); tick();
        end
        drive(0, 32'h0, 0);
        chk("s4_done", o_state, 3'd4);
        chk("s4_count", o_count, 4'd8);
        chk("s4_first_pc", rd_pc(), 32'h0040_0100);

        // 5: toggling ready; data held under stall, 8 pops in order.
        pops = 0; was_stall = 0;
        for (int c = 0; c < 40 && o_state == 3'd4; c++) begin
            i_rd_ready = c[0];
            if (was_stall) chk("s5_hold", o_rd_data, held);
            if (o_rd_valid && i_rd_ready) begin
                chk("s5_pc", rd_pc(), 32'h0040_0100 + 32'(4 * pops));
                pops++;
            end
            was_stall = o_rd_valid && !i_rd_ready;
            held = o_rd_data;
            tick();
        end
        chk("s5_pops", pops, 8);
        chk("s5_idle", o_state, 3'd0);
        i_rd_ready = 0;

        // 6a: abort during POST.
        i_mode = 2'd1; i_post_count = 4'd2; i_arm = 1; tick(); i_arm = 0;
        drive(1, 32'h0070_0000, 0); tick();
        drive(1, 32'h0070_0004, 1); tick();
        chk("s6_post", o_state, 3'd3);
        drive(0, 32'h0, 0); i_abort = 1; tick(); i_abort = 0;
        chk("s6_abort_state", o_state, 3'd0);
        chk("s6_abort_valid", o_rd_valid, 1'b0);
        chk("s6_abort_count", o_count, 4'd0);

        // 6b: async reset between edges mid-CAPTURE after an overflow.
        i_mode = 2'd1; i_arm = 1; tick(); i_arm = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h0080_0000 + 32'(4 * k), 0); tick();
        end
        drive(0, 32'h0, 0);
        chk("s6_pre_overflow", o_overflow, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("s6_rst_state", o_state, 3'd0);
        chk("s6_rst_count", o_count, 4'd0);
        chk("s6_rst_overflow", o_overflow, 1'b0);
        chk("s6_rst_valid", o_rd_valid, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        i_mode = 2'd0; i_arm = 1; tick(); i_arm = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'h0060_0000 + 32'(4 * k), 0); tick();
        end
        drive(0, 32'h0, 0);
        chk("s6_new_done", o_state, 3'd4);
        chk("s6_new_first", rd_pc(), 32'h0060_0000);
        i_rd_ready = 1;
        repeat (8) tick();
        chk("s6_new_idle", o_state, 3'd0);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            i_arm        = ($urandom_range(0, 7) == 0);
            i_mode       = 2'($urandom_range(0, 3));
            i_abort      = ($urandom_range(0, 63) == 0);
            i_post_count = 4'($urandom_range(0, 15));
            i_rd_ready   = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
